// File: rtl/ex_pipe_pkg.sv
// ex_pipe_pkg: shared widths, defaults and helpers for the EX pipeline
// register slice (ex_pipe_reg / ex_pipe_ctrl).
package ex_pipe_pkg;

    // Instruction field widths carried in EX payloads
    localparam int OPCODE_W   = 7;
    localparam int FUNCT7_W   = 7;
    localparam int FUNCT3_W   = 3;
    localparam int FUNCT3Y_W  = 3;
    localparam int FUNCT2R4_W = 2;
    localparam int RD_GROUP_W = 2;
    localparam int RD_INDEX_W = 5;
    localparam int PC_OPT_W   = 1;

    // Data path widths
    localparam int RF_DATA_W  = 32;
    localparam int M_DATA_W   = 512;

    // Slice defaults and fixed side-band widths
    localparam int EX_DATA_W_DEFAULT = 128;
    localparam int EX_DEPTH_DEFAULT  = 2;
    localparam int EX_DEPTH_MAX      = 8;
    localparam int COUNT_W           = 4;
    localparam int STALL_W           = 32;

    // Decoded control fields of an EX payload
    typedef struct packed {
        logic [OPCODE_W-1:0]   opcode;
        logic [FUNCT7_W-1:0]   funct7;
        logic [FUNCT3_W-1:0]   funct3;
        logic [FUNCT3Y_W-1:0]  funct3y;
        logic [FUNCT2R4_W-1:0] funct2r4;
        logic [RD_GROUP_W-1:0] rd_group;
        logic [RD_INDEX_W-1:0] rd_index;
        logic [PC_OPT_W-1:0]   pc_opt;
    } ex_ctrl_fields_t;

    localparam int EX_CTRL_FIELDS_W = $bits(ex_ctrl_fields_t);

    // Per-cycle transfer classification, {push, pop}
    typedef enum logic [1:0] {
        XFER_IDLE = 2'b00,
        XFER_POP  = 2'b01,
        XFER_PUSH = 2'b10,
        XFER_BOTH = 2'b11
    } xfer_e;

    // Pointer width: ceil(log2(depth)), but never narrower than one bit
    function automatic int ptr_width(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/ex_pipe_ctrl.sv
// ex_pipe_ctrl: pointer, occupancy and ready/valid control for ex_pipe_reg.
// Optional stall counter is built only when EX_PIPE_STALL_CNT_EN is defined;
// otherwise o_stall_cnt is a constant zero.
module ex_pipe_ctrl
    import ex_pipe_pkg::*;
#(
    parameter int DEPTH = EX_DEPTH_DEFAULT,
    parameter int PTR_W = ptr_width(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_in_valid,
    input  logic               i_out_ready,
    input  logic               i_flush,
    output logic               o_in_ready,
    output logic               o_out_valid,
    output logic               o_push,
    output logic [PTR_W-1:0]   o_wr_ptr,
    output logic [PTR_W-1:0]   o_rd_ptr,
    output logic [COUNT_W-1:0] o_count,
    output logic [STALL_W-1:0] o_stall_cnt
);

    localparam logic [PTR_W-1:0]   PTR_LAST  = PTR_W'(DEPTH - 1);
    localparam logic [COUNT_W-1:0] COUNT_MAX = COUNT_W'(DEPTH);

    logic [COUNT_W-1:0] r_count;
    logic [COUNT_W-1:0] w_count_nxt;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic               w_out_valid;
    logic               w_in_ready;
    logic               w_push;
    logic               w_pop;
    xfer_e              w_xfer;

    // Wrap explicitly at DEPTH-1 so non-power-of-two depths work
    function automatic logic [PTR_W-1:0] f_ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_LAST) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign w_out_valid = (r_count != '0);

    // Depth 1 must pass backpressure through to allow push-while-full;
    // deeper buffers decouple out_ready from in_ready.
    generate
        if (DEPTH == 1) begin : g_ready_pass
            assign w_in_ready = i_out_ready | ~w_out_valid;
        end else begin : g_ready_reg
            assign w_in_ready = (r_count < COUNT_MAX);
        end
    endgenerate

    assign w_push = i_in_valid & w_in_ready & ~i_flush;
    assign w_pop  = w_out_valid & i_out_ready;

    // Next occupancy from the push/pop combination of this cycle
    always_comb begin
        w_xfer      = xfer_e'({w_push, w_pop});
        w_count_nxt = r_count;
        case (w_xfer)
            XFER_PUSH: w_count_nxt = r_count + 1'b1;
            XFER_POP:  w_count_nxt = r_count - 1'b1;
            default:   w_count_nxt = r_count;
        endcase
    end

    // Occupancy and pointer state; flush outranks push and pop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_count <= w_count_nxt;
            if (w_push) begin
                r_wr_ptr <= f_ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= f_ptr_inc(r_rd_ptr);
            end
        end
    end

`ifdef EX_PIPE_STALL_CNT_EN
    logic [STALL_W-1:0] r_stall_cnt;

    // Count cycles where the head is held by downstream; saturates, ignores flush
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (w_out_valid && !i_out_ready && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign o_stall_cnt = r_stall_cnt;
`else
    assign o_stall_cnt = '0;
`endif

    assign o_in_ready  = w_in_ready;
    assign o_out_valid = w_out_valid;
    assign o_push      = w_push;
    assign o_wr_ptr    = r_wr_ptr;
    assign o_rd_ptr    = r_rd_ptr;
    assign o_count     = r_count;

endmodule

// File: rtl/ex_pipe_reg.sv
// ex_pipe_reg: DEPTH-entry valid/ready pipeline register for EX payloads.
// Control lives in ex_pipe_ctrl; payload storage is here and is never reset.
// Build option: define EX_PIPE_STALL_CNT_EN to enable the stall_cnt counter.
module ex_pipe_reg
    import ex_pipe_pkg::*;
#(
    parameter int DATA_W = EX_DATA_W_DEFAULT,
    parameter int DEPTH  = EX_DEPTH_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    input  logic               flush,
    output logic [COUNT_W-1:0] count,
    output logic [STALL_W-1:0] stall_cnt
);

    localparam int PTR_W = ptr_width(DEPTH);

    logic             w_push;
    logic [PTR_W-1:0] w_wr_ptr;
    logic [PTR_W-1:0] w_rd_ptr;

    ex_pipe_ctrl #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_ctrl (
        .clk         (clk),
        .rst         (rst),
        .i_in_valid  (in_valid),
        .i_out_ready (out_ready),
        .i_flush     (flush),
        .o_in_ready  (in_ready),
        .o_out_valid (out_valid),
        .o_push      (w_push),
        .o_wr_ptr    (w_wr_ptr),
        .o_rd_ptr    (w_rd_ptr),
        .o_count     (count),
        .o_stall_cnt (stall_cnt)
    );

    generate
        if (DEPTH == 1) begin : g_single
            logic [DATA_W-1:0] r_data;

            // Single slot: pointers are always zero, store directly
            always_ff @(posedge clk) begin
                if (w_push) begin
                    r_data <= in_data;
                end
            end

            assign out_data = r_data;
        end else begin : g_array
            logic [DATA_W-1:0] r_mem [DEPTH];

            // Write the accepted payload at the write pointer
            always_ff @(posedge clk) begin
                if (w_push) begin
                    r_mem[w_wr_ptr] <= in_data;
                end
            end

            assign out_data = r_mem[w_rd_ptr];
        end
    endgenerate

endmodule

// File: doc/ex_pipe_reg.md
EX_PIPE_REG -- requirements
Module: ex_pipe_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 128, meaning payload width in bits (legal 1..2048).
REQ-002 SHALL have parameter DEPTH, default 2, meaning buffer entries (legal 1..8).
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  upstream offers a payload.
REQ-006 SHALL have port in_ready  output  1  stage accepts a payload this cycle.
REQ-007 SHALL have port in_data  input  DATA_W  upstream payload.
REQ-008 SHALL have port out_valid  output  1  head entry is valid.
REQ-009 SHALL have port out_ready  input  1  downstream accepts the head entry.
REQ-010 SHALL have port out_data  output  DATA_W  head payload.
REQ-011 SHALL have port flush  input  1  discard all held and offered payloads.
REQ-012 SHALL have port count  output  4  number of valid entries, 0..DEPTH.
REQ-013 SHALL have port stall_cnt  output  32  backpressure cycle counter (see Configuration).

Function
REQ-014 SHALL define push = in_valid & in_ready & !flush and pop = out_valid & out_ready.
REQ-015 SHALL, for DEPTH=1, drive in_ready = out_ready | !out_valid (combinational pass-through of backpressure).
REQ-016 SHALL, for DEPTH>=2, drive in_ready = (count < DEPTH), a registered term with no combinational path from out_ready.
REQ-017 SHALL have 1-cycle latency: a payload pushed at edge N appears on out_data with out_valid=1 after edge N; no same-cycle fall-through when empty.
REQ-018 SHALL deliver payloads in push order, bit-exact.
REQ-019 SHALL hold out_data and out_valid stable while out_valid=1 and out_ready=0.
REQ-020 SHALL, on simultaneous push and pop, leave count unchanged and advance both pointers.
REQ-021 SHALL, for DEPTH=1 when full and out_ready=1, accept a new payload in the same cycle the old one is popped.
REQ-022 SHALL implement read/write pointers of ceil(log2(DEPTH)) bits that wrap from DEPTH-1 to 0, including non-power-of-two DEPTH.
REQ-023 SHALL, when flush=1, set count=0 and out_valid=0 after the edge, drop any same-cycle in_data, and give flush priority over push and pop.
REQ-024 SHALL ignore out_ready when out_valid=0 and ignore in_data when in_valid=0.
REQ-025 SHALL not gate payload storage by reset; only control state resets.

Reset
REQ-026 SHALL on rst=0, independent of clk, force count=0, out_valid=0, pointers=0, stall_cnt=0.
REQ-027 SHALL drive in_ready=1 during and after reset for DEPTH>=2, and in_ready=1 for DEPTH=1 since out_valid=0.
REQ-028 SHALL discard all entries when reset is asserted mid-transfer; out_data content after reset is don't-care.
REQ-029 SHALL resume normal operation on the first rising edge after rst returns to 1.

Configuration
REQ-030 SHALL, with macro EX_PIPE_STALL_CNT_EN defined, increment stall_cnt each cycle out_valid=1 and out_ready=0, saturating at 32'hFFFF_FFFF and unaffected by flush.
REQ-031 SHALL, without EX_PIPE_STALL_CNT_EN, tie stall_cnt to 0 and instantiate no counter logic.

Structure
REQ-032 SHALL take payload field widths and DATA_W constants (opcode 7, funct7 7, funct3 3, funct3Y 3, funct2R4 2, rd_group 2, rd_index 5, pc_opt 1, R/F data 32, M data 512) from shared package ex_pipe_pkg.
REQ-033 SHALL place pointer, count and ready/valid logic in one sub-module ex_pipe_ctrl; storage stays in ex_pipe_reg.

Verification
REQ-034 SHALL cover DEPTH=2, out_ready=1: push 0x11,0x22,0x33 on consecutive cycles -> same values out one cycle later, in_ready constant 1, count stays 1.
REQ-035 SHALL cover DEPTH=2, out_ready=0: push 0xA,0xB,0xC -> 0xA,0xB accepted, in_ready=0 on third cycle, count=2, out_data held at 0xA; one out_ready pulse pops 0xA, then in_ready=1.
REQ-036 SHALL cover DEPTH=1, full with out_ready=1 and in_valid=1 with 0x5 -> 0x5 accepted same cycle, count stays 1.
REQ-037 SHALL cover DEPTH=3 with 7 pushes and 7 pops interleaved -> pointer wrap, order preserved, count never exceeds 3.
REQ-038 SHALL cover flush=1 with count=2 and in_valid=1 -> next cycle count=0, out_valid=0, offered payload never appears.
REQ-039 SHALL cover rst=0 asserted between edges with count=2 -> count=0 and out_valid=0 immediately, before next clk edge; with EX_PIPE_STALL_CNT_EN, 5 stalled cycles give stall_cnt=5.
